// File: rtl/b_mductrl.sv
// Iterative unsigned shift-add multiply controller (multu) that owns HI/LO and serves mfhi/mflo.
// Latency: DATA_W busy cycles after start, then a one-cycle done pulse with HI/LO updated.
// Backpressure: stall is raised while busy when start/mfhi/mflo is presented; a start seen while busy is dropped.
module b_mductrl #(
  parameter  int DATA_W = 32,
  localparam int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              i_b_mductrl_clk,
  input  logic              i_b_mductrl_rst,
  input  logic              i_b_mductrl_start,
  input  logic [DATA_W-1:0] i_b_mductrl_rs_data,
  input  logic [DATA_W-1:0] i_b_mductrl_rt_data,
  input  logic              i_b_mductrl_rd_hi,
  input  logic              i_b_mductrl_rd_lo,
  output logic              o_b_mductrl_busy,
  output logic              o_b_mductrl_stall,
  output logic              o_b_mductrl_done,
  output logic [DATA_W-1:0] o_b_mductrl_hilo_data,
  output logic [DATA_W-1:0] o_b_mductrl_hi,
  output logic [DATA_W-1:0] o_b_mductrl_lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  state_t              state;
  logic [2*DATA_W-1:0] acc;
  logic [2*DATA_W-1:0] acc_next;
  logic [2*DATA_W-1:0] partial;
  logic [DATA_W-1:0]   mcand;
  logic [DATA_W-1:0]   mplier;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   hi;
  logic [DATA_W-1:0]   lo;

  always_comb begin
    partial  = {{DATA_W{1'b0}}, mcand} << cnt;
    acc_next = mplier[0] ? (acc + partial) : acc;
  end

  always_ff @(posedge i_b_mductrl_clk) begin
    if (i_b_mductrl_rst) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (i_b_mductrl_start) begin
            mcand  <= i_b_mductrl_rs_data;
            mplier <= i_b_mductrl_rt_data;
            acc    <= '0;
            cnt    <= '0;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          acc    <= acc_next;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          // Final iteration writes the product straight into HI/LO as DONE is entered.
          if (cnt == LAST_CNT) begin
            {hi, lo} <= acc_next;
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    o_b_mductrl_busy  = (state == RUN);
    o_b_mductrl_done  = (state == DONE);
    o_b_mductrl_stall = o_b_mductrl_busy &
                        (i_b_mductrl_start | i_b_mductrl_rd_hi | i_b_mductrl_rd_lo);
    o_b_mductrl_hilo_data = '0;
    if (!o_b_mductrl_busy) begin
      if (i_b_mductrl_rd_hi)      o_b_mductrl_hilo_data = hi;
      else if (i_b_mductrl_rd_lo) o_b_mductrl_hilo_data = lo;
    end
    o_b_mductrl_hi = hi;
    o_b_mductrl_lo = lo;
  end

endmodule

// File: tb/tb_b_mductrl.sv
// Directed bench for b_mductrl: products are modelled in the bench and queued at start, compared at done.
module tb_b_mductrl;

  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              rd_hi;
  logic              rd_lo;
  logic              busy;
  logic              stall;
  logic              done;
  logic [DATA_W-1:0] hilo_data;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  int checks = 0;
  int errors = 0;
  logic [2*DATA_W-1:0] sb[$];

  always #5 clk = ~clk;

  b_mductrl #(.DATA_W(DATA_W)) dut (
    .i_b_mductrl_clk      (clk),
    .i_b_mductrl_rst      (rst),
    .i_b_mductrl_start    (start),
    .i_b_mductrl_rs_data  (rs_data),
    .i_b_mductrl_rt_data  (rt_data),
    .i_b_mductrl_rd_hi    (rd_hi),
    .i_b_mductrl_rd_lo    (rd_lo),
    .o_b_mductrl_busy     (busy),
    .o_b_mductrl_stall    (stall),
    .o_b_mductrl_done     (done),
    .o_b_mductrl_hilo_data(hilo_data),
    .o_b_mductrl_hi       (hi),
    .o_b_mductrl_lo       (lo)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] wa, wb;
    wa = {32'h0, a};
    wb = {32'h0, b};
    return wa * wb;
  endfunction

  // Drive a start at the next negedge and queue the expected product.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; rs_data = a; rt_data = b;
    sb.push_back(model(a, b));
    #1;
  endtask

  task automatic wait_done(output int nbusy, output bit ok);
    nbusy = 0; ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (done) begin ok = 1'b1; break; end
      if (busy) nbusy++;
    end
  endtask

  task automatic pop_check(input string tag);
    logic [63:0] exp;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      exp = sb.pop_front();
      chk({tag, "_hi"}, {32'h0, hi}, {32'h0, exp[63:32]});
      chk({tag, "_lo"}, {32'h0, lo}, {32'h0, exp[31:0]});
    end
  endtask

  task automatic mul_check(input string tag, input logic [31:0] a, input logic [31:0] b);
    int  nb;
    bit  ok;
    issue(a, b);
    chk({tag, "_start_stall"}, {63'h0, stall}, 64'd0);
    @(negedge clk);
    start = 1'b0;
    #1;
    chk({tag, "_busy_rise"}, {63'h0, busy}, 64'd1);
    wait_done(nb, ok);
    chk({tag, "_done_seen"}, {63'h0, ok}, 64'd1);
    chk({tag, "_busy_cycles"}, 64'(nb + 1), 64'd32);
    pop_check(tag);
  endtask

  initial begin
    int  nb;
    bit  ok;
    bit  seen_done;
    logic [63:0] exp;

    rst = 1'b1; start = 1'b1; rs_data = 32'h1; rt_data = 32'h1; rd_hi = 1'b0; rd_lo = 1'b0;

    // 1: reset held two cycles with start asserted
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      chk("rst_busy", {63'h0, busy}, 64'd0);
      chk("rst_stall", {63'h0, stall}, 64'd0);
      chk("rst_done", {63'h0, done}, 64'd0);
    end
    chk("rst_hi", {32'h0, hi}, 64'd0);
    chk("rst_lo", {32'h0, lo}, 64'd0);
    chk("rst_hilo", {32'h0, hilo_data}, 64'd0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    #1;
    chk("rst_idle_busy", {63'h0, busy}, 64'd0);

    // 2: 3 x 5, then mflo
    mul_check("m3x5", 32'h3, 32'h5);
    @(negedge clk);
    rd_lo = 1'b1;
    #1;
    chk("m3x5_done_pulse", {63'h0, done}, 64'd0);
    chk("m3x5_mflo", {32'h0, hilo_data}, 64'h0000000F);
    rd_lo = 1'b0;

    // 3: boundary operands
    mul_check("mffxff", 32'hFFFFFFFF, 32'hFFFFFFFF);
    mul_check("m80x2", 32'h80000000, 32'h00000002);

    // 4: mfhi raised 5 cycles into the multiply and held
    issue(32'hDEADBEEF, 32'h00012345);
    exp = sb[0];
    ok = 1'b0;
    for (int c = 1; c < 100; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c >= 5) rd_hi = 1'b1;
      #1;
      if (done) begin ok = 1'b1; break; end
      if (c == 5) chk("mfhi_stall", {63'h0, stall}, 64'd1);
      if (c == 20) chk("mfhi_busy_zero", {32'h0, hilo_data}, 64'd0);
    end
    chk("mfhi_done_seen", {63'h0, ok}, 64'd1);
    chk("mfhi_done_stall", {63'h0, stall}, 64'd0);
    chk("mfhi_done_data", {32'h0, hilo_data}, {32'h0, exp[63:32]});
    pop_check("mfhi");
    rd_hi = 1'b0;

    // 5: second start held through RUN, then accepted in DONE
    issue(32'h00000007, 32'h00000009);
    ok = 1'b0;
    for (int c = 1; c < 100; c++) begin
      @(negedge clk);
      start = 1'b1; rs_data = 32'h0000ABCD; rt_data = 32'h00001111;
      #1;
      if (done) begin ok = 1'b1; break; end
      if (c == 3 || c == 31) chk("held_start_stall", {63'h0, stall}, 64'd1);
    end
    chk("b2b_done_seen", {63'h0, ok}, 64'd1);
    chk("b2b_done_stall", {63'h0, stall}, 64'd0);
    pop_check("b2b_first");
    sb.push_back(model(32'h0000ABCD, 32'h00001111));
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("b2b_busy_rerise", {63'h0, busy}, 64'd1);
    wait_done(nb, ok);
    chk("b2b2_done_seen", {63'h0, ok}, 64'd1);
    chk("b2b2_busy_cycles", 64'(nb + 1), 64'd32);
    pop_check("b2b_second");

    // 6: reset at RUN cycle 10 aborts with no write
    @(negedge clk);
    start = 1'b1; rs_data = 32'h00001234; rt_data = 32'h00005678;
    for (int c = 1; c < 10; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy_before", {63'h0, busy}, 64'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_busy", {63'h0, busy}, 64'd0);
    chk("abort_hi", {32'h0, hi}, 64'd0);
    chk("abort_lo", {32'h0, lo}, 64'd0);
    seen_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (done) seen_done = 1'b1;
    end
    chk("abort_no_done", {63'h0, seen_done}, 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/b_mductrl.md
Name: b_mductrl

Overview:
- Multi-cycle multiply/divide-unit controller for the EX stage of the MIPS pipeline.
- Sequences an iterative unsigned shift-add multiplier for `multu` and owns the architectural HI/LO registers.
- Serves `mfhi`/`mflo` reads and raises a pipeline stall while a multiply is in flight, so the hazard unit can freeze IF/ID/EX.
- Sits beside b_alu; it is driven by the ALU-control/decode outputs that identify `multu` (funct 011001), `mfhi` and `mflo`.

Parameters:
- DATA_W, 32, operand width; product is 2*DATA_W, HI = upper DATA_W bits, LO = lower DATA_W bits.
- CNT_W, $clog2(DATA_W)+1, iteration counter width (derived, not overridden).

Ports:
- i_b_mductrl_clk  input  1  system clock, rising edge.
- i_b_mductrl_rst  input  1  synchronous, active-high reset.
- i_b_mductrl_start  input  1  `multu` valid in EX this cycle.
- i_b_mductrl_rs_data  input  DATA_W  multiplicand (rs).
- i_b_mductrl_rt_data  input  DATA_W  multiplier (rt).
- i_b_mductrl_rd_hi  input  1  `mfhi` valid in EX.
- i_b_mductrl_rd_lo  input  1  `mflo` valid in EX.
- o_b_mductrl_busy  output  1  multiply iterating.
- o_b_mductrl_stall  output  1  freeze pipeline (combinational).
- o_b_mductrl_done  output  1  one-cycle pulse: HI/LO just updated.
- o_b_mductrl_hilo_data  output  DATA_W  mfhi/mflo result to the EX result mux.
- o_b_mductrl_hi  output  DATA_W  HI register (debug/observability).
- o_b_mductrl_lo  output  DATA_W  LO register.

Behaviour:
- Clock and reset: single clock i_b_mductrl_clk; i_b_mductrl_rst is synchronous and active-high.
- Reset:
  - State goes to IDLE.
  - HI, LO, accumulator, multiplicand, multiplier and counter all clear to 0.
  - busy, done and stall are 0; hilo_data is 0.
  - Reset overrides all other inputs, including a reset in the middle of a multiply, which is aborted with no HI/LO write.
- FSM states:
  - IDLE: start=1 moves to RUN, else stays IDLE.
  - RUN: when counter==DATA_W-1 at the clock edge, moves to DONE; else stays RUN.
  - DONE: start=1 moves to RUN (back-to-back), else IDLE.
- Start acceptance (IDLE or DONE, start=1), at the edge:
  - Capture multiplicand=rs_data and multiplier=rt_data.
  - Clear the 2*DATA_W-bit accumulator; counter=0.
- RUN iteration, every cycle:
  - If multiplier[0]=1, add multiplicand<<counter into the accumulator (2*DATA_W-bit add, no overflow possible).
  - Shift the multiplier right by 1; counter+1.
- Write-back:
  - The final iteration's result is written into {HI,LO} at the same edge that enters DONE.
  - HI/LO are updated only by a completed multiply or by reset.
- Latency:
  - Start sampled at edge 0.
  - busy=1 for exactly DATA_W cycles (edges 1..DATA_W are iterations).
  - done=1 during the DONE cycle, where HI/LO already hold the new product.
- busy: busy = (state==RUN).
- stall: stall = busy & (start | rd_hi | rd_lo).
  - The pipeline holds the instruction and re-presents it; a start seen while busy is ignored (not queued).
- Reads (combinational hilo_data):
  - When not busy: rd_hi returns HI, rd_lo returns LO.
  - rd_hi and rd_lo together: HI wins.
  - Neither asserted, or busy: hilo_data=0.
- start together with rd_hi/rd_lo while not busy: the read returns the pre-multiply HI/LO; start is accepted; no stall.
- DONE cycle: reads return the new product; no stall.
- Operands are unsigned; there is no signed `mult`, no divide and no mthi/mtlo in this block.

Test Plan:
1. Reset asserted 2 cycles: busy/stall/done=0, hi=lo=0, hilo_data=0. Hold reset with start=1: state stays IDLE.
2. multu rs=0x00000003, rt=0x00000005: busy high 32 cycles, done pulse in cycle 33, lo=0x0000000F, hi=0; mflo gives hilo_data=0x0000000F.
3. multu 0xFFFFFFFF x 0xFFFFFFFF: hi=0xFFFFFFFE, lo=0x00000001. Also multu 0x80000000 x 0x00000002: hi=0x00000001, lo=0.
4. mfhi asserted 5 cycles after start and held: stall=1 until busy falls; in the DONE cycle stall=0 and hilo_data=new HI.
5. Second start held during RUN: stall=1 and operands unchanged. Same start in the DONE cycle: accepted, busy re-rises next cycle, second product correct.
6. Reset asserted at RUN cycle 10 of 0x1234 x 0x5678: next cycle busy=0, hi=lo=0, no done pulse.
